// File: rtl/conv_window_sequencer_pkg.sv
// Shared types and default geometry for the sliding-window sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package conv_pkg;

  typedef enum logic [2:0] {IDLE, FILL, SCAN, LOAD, DONE} state_t;

  localparam int DEF_IMAGE_WIDTH  = 5;
  localparam int DEF_IMAGE_HEIGHT = 5;
  localparam int DEF_FILTER_SIZE  = 3;
  localparam int DEF_PIX_W        = 8;

  localparam int N_COLS = DEF_IMAGE_WIDTH - DEF_FILTER_SIZE + 1;
  localparam int N_ROWS = DEF_IMAGE_HEIGHT - DEF_FILTER_SIZE + 1;
  localparam int BUF_W  = DEF_FILTER_SIZE * DEF_IMAGE_WIDTH * DEF_PIX_W;
  localparam int WIN_W  = DEF_FILTER_SIZE * DEF_FILTER_SIZE * DEF_PIX_W;

endpackage

// File: rtl/conv_window_sequencer_window_extract.sv
// Slices one FILTER_SIZE x FILTER_SIZE window out of the band buffer at column col.
// Latency: purely combinational.
// Backpressure: none; the owner holds band/col stable while the window is stalled.
module window_extract
  import conv_pkg::*;
#(
  parameter int IMAGE_WIDTH = DEF_IMAGE_WIDTH,
  parameter int FILTER_SIZE = DEF_FILTER_SIZE,
  parameter int PIX_W       = DEF_PIX_W,
  parameter int COL_W       = (IMAGE_WIDTH > 1) ? $clog2(IMAGE_WIDTH) : 1
) (
  input  logic [FILTER_SIZE*IMAGE_WIDTH*PIX_W-1:0] band,
  input  logic [COL_W-1:0]                         col,
  output logic [FILTER_SIZE*FILTER_SIZE*PIX_W-1:0] win
);

  // Element (i,j) of the window is band row i, column col+j.
  for (genvar i = 0; i < FILTER_SIZE; i++) begin : g_row
    for (genvar j = 0; j < FILTER_SIZE; j++) begin : g_col
      assign win[(i*FILTER_SIZE+j)*PIX_W +: PIX_W] =
        band[(i*IMAGE_WIDTH + j + int'(col))*PIX_W +: PIX_W];
    end
  end

endmodule

// File: rtl/conv_window_sequencer.sv
// Frame controller: buffers a FILTER_SIZE-row band and emits every window in raster order.
// Latency: first window one cycle after the last band pixel; back-to-back windows at full rate.
// Backpressure: pix_ready low while scanning; a window holds stable until win_ready.
module conv_window_sequencer
  import conv_pkg::*;
#(
  parameter int IMAGE_WIDTH  = DEF_IMAGE_WIDTH,
  parameter int IMAGE_HEIGHT = DEF_IMAGE_HEIGHT,
  parameter int FILTER_SIZE  = DEF_FILTER_SIZE,
  parameter int PIX_W        = DEF_PIX_W,
  localparam int ROW_W = (IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1,
  localparam int COL_W = (IMAGE_WIDTH > 1) ? $clog2(IMAGE_WIDTH) : 1,
  localparam int BW    = FILTER_SIZE * IMAGE_WIDTH * PIX_W,
  localparam int WW    = FILTER_SIZE * FILTER_SIZE * PIX_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [PIX_W-1:0] pix_in,
  input  logic             pix_valid,
  output logic             pix_ready,
  output logic [WW-1:0]    win_out,
  output logic             win_valid,
  input  logic             win_ready,
  output logic [ROW_W-1:0] win_row,
  output logic [COL_W-1:0] win_col,
  output logic             busy,
  output logic             frame_done
);

  localparam int CNT_W = (FILTER_SIZE*IMAGE_WIDTH > 1) ? $clog2(FILTER_SIZE*IMAGE_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_FILL = CNT_W'(FILTER_SIZE*IMAGE_WIDTH - 1);
  localparam logic [CNT_W-1:0] LAST_LOAD = CNT_W'(IMAGE_WIDTH - 1);
  localparam logic [COL_W-1:0] LAST_COL  = COL_W'(IMAGE_WIDTH - FILTER_SIZE);
  localparam logic [ROW_W-1:0] LAST_ROW  = ROW_W'(IMAGE_HEIGHT - FILTER_SIZE);
  localparam int BOTTOM_BASE = (FILTER_SIZE - 1) * IMAGE_WIDTH;

  state_t           state;
  logic [CNT_W-1:0] pix_cnt;
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic [BW-1:0]    band;

  // FSM, counters, band buffer and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      pix_cnt    <= '0;
      col        <= '0;
      row        <= '0;
      band       <= '0;
      pix_ready  <= 1'b0;
      win_valid  <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state     <= FILL;
            pix_cnt   <= '0;
            col       <= '0;
            row       <= '0;
            pix_ready <= 1'b1;
            busy      <= 1'b1;
          end
        end
        FILL: begin
          // pix_cnt is row*W+col, which is exactly the flat buffer index.
          if (pix_valid) begin
            band[int'(pix_cnt)*PIX_W +: PIX_W] <= pix_in;
            if (pix_cnt == LAST_FILL) begin
              pix_cnt   <= '0;
              state     <= SCAN;
              pix_ready <= 1'b0;
              win_valid <= 1'b1;
            end else begin
              pix_cnt <= pix_cnt + CNT_W'(1);
            end
          end
        end
        SCAN: begin
          if (win_ready) begin
            if (col < LAST_COL) begin
              col <= col + COL_W'(1);
            end else begin
              col <= '0;
              if (row == LAST_ROW) begin
                state      <= DONE;
                win_valid  <= 1'b0;
                frame_done <= 1'b1;
              end else begin
                // Slide down one image row; the bottom row is refilled in LOAD.
                row       <= row + ROW_W'(1);
                band      <= band >> (IMAGE_WIDTH*PIX_W);
                state     <= LOAD;
                win_valid <= 1'b0;
                pix_ready <= 1'b1;
              end
            end
          end
        end
        LOAD: begin
          if (pix_valid) begin
            band[(BOTTOM_BASE + int'(pix_cnt))*PIX_W +: PIX_W] <= pix_in;
            if (pix_cnt == LAST_LOAD) begin
              pix_cnt   <= '0;
              state     <= SCAN;
              pix_ready <= 1'b0;
              win_valid <= 1'b1;
            end else begin
              pix_cnt <= pix_cnt + CNT_W'(1);
            end
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  window_extract #(
    .IMAGE_WIDTH(IMAGE_WIDTH),
    .FILTER_SIZE(FILTER_SIZE),
    .PIX_W      (PIX_W),
    .COL_W      (COL_W)
  ) u_extract (
    .band(band),
    .col (col),
    .win (win_out)
  );

  assign win_row = row;
  assign win_col = col;

endmodule
